change_logger: RTL and testbench

Synthesizable event monitor: samples a WIDTH-bit signal bus every clock, detects any change relative to the previous sample, and queues a timestamped record of each change in an internal FIFO. Records drain through a valid/ready interface to a consumer (UART dumper, debug bus, or bench scoreboard). This is the hardware counterpart of a simulation-only `$display`-on-change procedure: it is the observing end of a stimulus sequence. It produces the same change log cycle-accurately in silicon.

---
 rtl/change_logger.sv | 121 ++++++++++++
 tb/tb_change_logger.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/change_logger.sv
// Change logger: samples sig_in every clock and queues a {timestamp, sample}
// record for every change into a FIFO that drains over a valid/ready port.
module change_logger #(
  parameter int WIDTH    = 3,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              sig_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TS_WIDTH+WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow,
  output logic [7:0]                    drop_count,
  input  logic                          ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = TS_WIDTH + WIDTH;

  logic [TS_WIDTH-1:0] ts_reg;
  logic [WIDTH-1:0]    prev_reg;
  logic                armed_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [LVL_W-1:0]    level_reg;
  logic [LVL_W-1:0]    level_next;
  logic                overflow_reg;
  logic                overflow_next;
  logic [7:0]          drop_count_reg;
  logic [7:0]          drop_count_next;
  logic [REC_W-1:0]    mem [DEPTH];

  logic [WIDTH-1:0]    bit_diff;
  logic                empty;
  logic                full;
  logic                push_req;
  logic                push;
  logic                pop;
  logic                drop;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_diff
      assign bit_diff[gi] = sig_in[gi] ^ prev_reg[gi];
    end
  endgenerate

  assign empty    = (level_reg == '0);
  assign full     = (level_reg == LVL_W'(DEPTH));
  assign pop      = !empty && out_ready;
  assign push_req = armed_reg && (|bit_diff);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  // A drop on the same edge as a clear wins: the flag stays set and the count restarts at one.
  always_comb begin
    overflow_next   = overflow_reg;
    drop_count_next = drop_count_reg;
    if (drop) begin
      overflow_next = 1'b1;
      if (ovf_clr)
        drop_count_next = 8'd1;
      else if (drop_count_reg != 8'hFF)
        drop_count_next = drop_count_reg + 8'd1;
    end else if (ovf_clr) begin
      overflow_next   = 1'b0;
      drop_count_next = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_reg         <= '0;
      prev_reg       <= '0;
      armed_reg      <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'd0;
    end else begin
      ts_reg         <= ts_reg + TS_WIDTH'(1);
      prev_reg       <= sig_in;
      armed_reg      <= 1'b1;
      level_reg      <= level_next;
      overflow_reg   <= overflow_next;
      drop_count_reg <= drop_count_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  // Storage needs no reset: entries are only visible once counted in level.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr_reg] <= {ts_reg, sig_in};
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem[rd_ptr_reg];
  assign level      = level_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_change_logger.sv
// Directed bench for change_logger: stimulus pushes expected records into a
// queue, a negedge monitor pops and compares each accepted DUT record.
module tb_change_logger;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sig_in = 3'b010;
  logic        out_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        out_valid;
  logic [18:0] out_data;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  drop_count;

  logic        out_valid2;
  logic [6:0]  out_data2;
  logic [3:0]  level2;
  logic        overflow2;
  logic [7:0]  drop_count2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [18:0] sb[$];
  logic [18:0] exp_rec;

  change_logger #(.WIDTH(3), .DEPTH(8), .TS_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .level(level),
    .overflow(overflow), .drop_count(drop_count), .ovf_clr(ovf_clr)
  );

  change_logger #(.WIDTH(3), .DEPTH(8), .TS_WIDTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .sig_in(sig_in), .out_valid(out_valid2),
    .out_ready(1'b1), .out_data(out_data2), .level(level2),
    .overflow(overflow2), .drop_count(drop_count2), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record actual=%0h required=none", out_data);
      end else begin
        exp_rec = sb.pop_front();
        $display("rec ts=%0d sample=%b", out_data[18:3], out_data[2:0]);
        chk("record", 32'(out_data), 32'(exp_rec));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ts(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset(input logic [2:0] s);
    rst = 1'b1;
    sig_in = s;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    step();
    step();
    sb.delete();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drops", 32'(drop_count), 0);
    chk("rst_data", 32'(out_data), 0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic toggle(input bit store);
    sig_in[0] = ~sig_in[0];
    if (store) sb.push_back({16'(cyc), sig_in});
    step();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && level != 0; i++) step();
    chk("drain_level", 32'(level), 0);
    chk("drain_sb_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Baseline: startup level must not be logged.
    do_reset(3'b010);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("base_valid", 32'(out_valid), 0);
      chk("base_level", 32'(level), 0);
    end

    // Single changes with a ready consumer.
    do_reset(3'b010);
    out_ready = 1'b1;
    wait_ts(2);
    sig_in = 3'b011;
    sb.push_back({16'd2, 3'b011});
    chk("pre_valid", 32'(out_valid), 0);
    step();
    chk("lat_valid_2", 32'(out_valid), 1);
    wait_ts(12);
    sig_in = 3'b001;
    sb.push_back({16'd12, 3'b001});
    step();
    chk("lat_valid_12", 32'(out_valid), 1);
    wait_ts(22);
    sig_in = 3'b000;
    sb.push_back({16'd22, 3'b000});
    step();
    chk("lat_valid_22", 32'(out_valid), 1);
    drain();

    // Backpressure: ten changes into eight slots.
    do_reset(3'b010);
    wait_ts(2);
    for (int i = 0; i < 10; i++) toggle(i < 8);
    chk("full_level", 32'(level), 8);
    chk("full_ovf", 32'(overflow), 1);
    chk("full_drops", 32'(drop_count), 2);
    chk("full_head", 32'(out_data), 32'({16'd2, 3'b011}));

    // Push and pop on the same edge while full.
    out_ready = 1'b1;
    toggle(1'b1);
    chk("pp_level", 32'(level), 8);
    chk("pp_drops", 32'(drop_count), 2);
    drain();

    // Clear colliding with a drop, then saturation.
    do_reset(3'b010);
    wait_ts(2);
    for (int i = 0; i < 13; i++) toggle(i < 8);
    chk("five_drops", 32'(drop_count), 5);
    chk("five_ovf", 32'(overflow), 1);
    ovf_clr = 1'b1;
    toggle(1'b0);
    ovf_clr = 1'b0;
    chk("clr_drop_ovf", 32'(overflow), 1);
    chk("clr_drop_cnt", 32'(drop_count), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_cnt", 32'(drop_count), 0);
    for (int i = 0; i < 260; i++) toggle(1'b0);
    chk("sat_cnt", 32'(drop_count), 255);
    chk("sat_level", 32'(level), 8);
    drain();

    // Mid-operation reset discards queued records.
    do_reset(3'b010);
    wait_ts(2);
    for (int i = 0; i < 3; i++) toggle(1'b1);
    chk("mid_level", 32'(level), 3);
    rst = 1'b1;
    sig_in = 3'b101;
    sb.delete();
    step();
    rst = 1'b0;
    cyc = 0;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    for (int i = 0; i < 5; i++) step();
    chk("mid_baseline", 32'(level), 0);

    // Timestamp wrap on the 4-bit instance: count 17 logs as 1.
    out_ready = 1'b1;
    wait_ts(17);
    sig_in = 3'b100;
    sb.push_back({16'd17, 3'b100});
    step();
    chk("wrap_valid", 32'(out_valid2), 1);
    chk("wrap_data", 32'(out_data2), 32'({4'd1, 3'b100}));
    drain();

    chk("final_sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
